// File: rtl/attn_output_projector.sv
// Projects a 12-element attention vector back to the 16-element model domain.
// One W_o row per cycle; each result is saturated to 16 bits and flagged on overflow.
module attn_output_projector #(
  parameter int IN_DIM  = 12,
  parameter int OUT_DIM = 16,
  parameter int DW      = 16,
  parameter int ACC_W   = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_DIM*DW-1:0]          in_vec,
  input  logic [OUT_DIM*IN_DIM*DW-1:0]  w_o,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_DIM*DW-1:0]         out_vec,
  output logic [OUT_DIM-1:0]            ovf_mask,
  output logic                          overflow
);

  localparam int RW  = $clog2(OUT_DIM);
  localparam int RWW = IN_DIM * DW;
  localparam int PW  = 2 * DW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [RW-1:0] LAST_ROW = RW'(OUT_DIM - 1);

  localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [1:0]      state;
  logic [RW-1:0]   row;
  logic [RWW-1:0]  x_q;

  logic [RWW-1:0]          w_row;
  logic signed [DW-1:0]    x_e [IN_DIM];
  logic signed [DW-1:0]    w_e [IN_DIM];
  logic signed [PW-1:0]    prod [IN_DIM];
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-DW:0]       acc_hi;
  logic                    sat;
  logic [DW-1:0]           sat_val;

  logic accept;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign overflow  = |ovf_mask;
  assign accept    = in_valid && in_ready;

  // Row select stays a constant-index mux so no wide multiply lands on the index.
  always_comb begin
    w_row = '0;
    for (int r = 0; r < OUT_DIM; r++) begin
      if (row == RW'(r)) begin
        w_row = w_o[r*RWW +: RWW];
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int c = 0; c < IN_DIM; c++) begin
      x_e[c]  = x_q[c*DW +: DW];
      w_e[c]  = w_row[c*DW +: DW];
      prod[c] = w_e[c] * x_e[c];
      acc     = acc + {{(ACC_W-PW){prod[c][PW-1]}}, prod[c]};
    end
  end

  // In range only when every bit above the result MSB matches the sign.
  always_comb begin
    acc_hi = acc[ACC_W-1:DW-1];
    sat    = !((&acc_hi) || (~|acc_hi));
    if (!sat) begin
      sat_val = acc[DW-1:0];
    end else if (acc[ACC_W-1]) begin
      sat_val = SAT_NEG;
    end else begin
      sat_val = SAT_POS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      row      <= '0;
      x_q      <= '0;
      out_vec  <= '0;
      ovf_mask <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (accept) begin
            x_q      <= in_vec;
            out_vec  <= '0;
            ovf_mask <= '0;
            row      <= '0;
            state    <= S_COMPUTE;
          end
        end
        (state == S_COMPUTE): begin
          out_vec[row*DW +: DW] <= sat_val;
          ovf_mask[row]         <= sat;
          row                   <= row + 1'b1;
          if (row == LAST_ROW) begin
            state <= S_DONE;
          end
        end
        (state == S_DONE): begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
